station_cmd_cntrl: RTL and testbench

- Sequences the barcode station reader against commands from the UART command path.
- Accepts a GO command carrying a destination station ID and asserts go while the robot is in transit.
- Consumes each ID_vld/ID report from the barcode reader and stops on a destination match.
- Drives a piezo alarm when motion is requested but blocked by an obstacle (OK2Move low).

---
 rtl/station_cmd_pkg.sv | 13 +
 rtl/piezo_drv.sv | 47 ++++
 rtl/station_cmd_cntrl.sv | 75 +++++++
 tb/tb_station_cmd_cntrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/station_cmd_pkg.sv
// Shared types and constants for the station command controller.
//   state_t  : controller state (IDLE parked, MOVING while a GO is outstanding)
//   CMD_*    : opcodes carried in cmd[7:6]
//   ID_FMT   : required value of ID[7:6] for a valid station report
package station_cmd_pkg;

  typedef enum logic {IDLE, MOVING} state_t;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_GO   = 2'b01;
  localparam logic [1:0] ID_FMT   = 2'b00;

endpackage

// File: rtl/piezo_drv.sv
// Piezo tone generator. While en is high, buzz toggles every BUZZ_HALF_PERIOD clocks
// (buzz goes to 1 first) and buzz_n is its complement; while en is low both legs are
// held at 0 so no DC sits across the piezo.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : tone request
//   buzz       : piezo positive leg (registered)
//   buzz_n     : piezo negative leg (registered)
module piezo_drv #(
  parameter int unsigned BUZZ_HALF_PERIOD = 12500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic buzz,
  output logic buzz_n
);

  localparam logic [15:0] LastCnt = 16'(BUZZ_HALF_PERIOD - 1);

  logic [15:0] cnt_q;
  logic        buzz_q;
  logic        buzz_n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 16'h0000;
      buzz_q   <= 1'b0;
      buzz_n_q <= 1'b0;
    end else if (!en) begin
      cnt_q    <= 16'h0000;
      buzz_q   <= 1'b0;
      buzz_n_q <= 1'b0;
    end else if (cnt_q == LastCnt) begin
      cnt_q    <= 16'h0000;
      buzz_q   <= ~buzz_q;
      buzz_n_q <= buzz_q;
    end else begin
      cnt_q    <= cnt_q + 16'h0001;
      // Drive the negative leg as soon as the tone starts.
      buzz_n_q <= ~buzz_q;
    end
  end

  assign buzz   = buzz_q;
  assign buzz_n = buzz_n_q;

endmodule

// File: rtl/station_cmd_cntrl.sv
// Station command controller: takes GO/STOP commands from the UART path, enables motion
// while in transit, stops when the barcode reader reports the destination station, and
// sounds a piezo alarm while motion is requested but blocked by an obstacle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd, cmd_rdy        : command byte ([7:6] opcode, [5:0] dest ID) and its valid flag
//   clr_cmd_rdy         : one-cycle acknowledge of cmd_rdy
//   ID, ID_vld          : station report from the barcode reader and its valid flag
//   clr_ID_vld          : one-cycle acknowledge of ID_vld
//   OK2Move             : path clear
//   go, in_transit      : motion enable, GO outstanding
//   buzz, buzz_n        : piezo drive legs
module station_cmd_cntrl
  import station_cmd_pkg::*;
#(
  parameter int unsigned BUZZ_HALF_PERIOD = 12500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic       OK2Move,
  output logic       go,
  output logic       in_transit,
  output logic       buzz,
  output logic       buzz_n
);

  state_t     state_q;
  logic [5:0] dest_id_q;
  logic       id_match;

  assign id_match = (ID[7:6] == ID_FMT) && (ID[5:0] == dest_id_q);

  // Both flags are held by their sources until acknowledged, and every flag is consumed
  // in the cycle it is seen, so the acknowledges follow the flags directly.
  assign clr_cmd_rdy = cmd_rdy;
  assign clr_ID_vld  = ID_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dest_id_q <= 6'h00;
    end else if (cmd_rdy) begin
      // A coincident ID report is stale: the command alone decides.
      case (cmd[7:6])
        CMD_GO: begin
          dest_id_q <= cmd[5:0];
          state_q   <= MOVING;
        end
        CMD_STOP: state_q <= IDLE;
        default:  state_q <= state_q;
      endcase
    end else if (ID_vld && (state_q == MOVING) && id_match) begin
      state_q <= IDLE;
    end
  end

  assign in_transit = (state_q == MOVING);
  assign go         = in_transit & OK2Move;

  piezo_drv #(
    .BUZZ_HALF_PERIOD(BUZZ_HALF_PERIOD)
  ) u_piezo_drv (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_transit & ~OK2Move),
    .buzz  (buzz),
    .buzz_n(buzz_n)
  );

endmodule

// File: tb/tb_station_cmd_cntrl.sv
module tb_station_cmd_cntrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       clr_ID_vld;
  logic       OK2Move;
  logic       go;
  logic       in_transit;
  logic       buzz;
  logic       buzz_n;

  station_cmd_cntrl #(
    .BUZZ_HALF_PERIOD(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .ID         (ID),
    .ID_vld     (ID_vld),
    .clr_ID_vld (clr_ID_vld),
    .OK2Move    (OK2Move),
    .go         (go),
    .in_transit (in_transit),
    .buzz       (buzz),
    .buzz_n     (buzz_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic clr_cmd;
    logic clr_id;
    logic transit;
    logic go;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT acknowledges, checks the acks, then
  // checks the resulting state on the following sample.
  exp_t pend_e;
  logic pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      chk("post_in_transit", {31'b0, in_transit}, {31'b0, pend_e.transit});
      chk("post_go", {31'b0, go}, {31'b0, pend_e.go});
      pend = 1'b0;
    end
    if (rst_n && (clr_cmd_rdy || clr_ID_vld)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got cmd=%b id=%b, expected none", clr_cmd_rdy, clr_ID_vld);
      end else begin
        pend_e = sb_q.pop_front();
        chk("clr_cmd_rdy", {31'b0, clr_cmd_rdy}, {31'b0, pend_e.clr_cmd});
        chk("clr_ID_vld", {31'b0, clr_ID_vld}, {31'b0, pend_e.clr_id});
        pend = 1'b1;
      end
    end
  end

  // Source model: raise the flag(s), hold until acknowledged (bounded), drop at the edge.
  task automatic send(input logic do_cmd, input logic [7:0] c, input logic do_id,
                      input logic [7:0] i, input exp_t e);
    logic acked;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (do_cmd) begin
      cmd     = c;
      cmd_rdy = 1'b1;
    end
    if (do_id) begin
      ID     = i;
      ID_vld = 1'b1;
    end
    acked = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if ((!do_cmd || clr_cmd_rdy) && (!do_id || clr_ID_vld)) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack, expected ack within 8 cycles");
    end
    @(posedge clk);
    #1;
    cmd_rdy = 1'b0;
    ID_vld  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c, input exp_t e);
    send(1'b1, c, 1'b0, 8'h00, e);
  endtask

  task automatic send_id(input logic [7:0] i, input exp_t e);
    send(1'b0, 8'h00, 1'b1, i, e);
  endtask

  // {clr_cmd, clr_id, transit, go}
  localparam exp_t CmdMove = 4'b1011;
  localparam exp_t CmdIdle = 4'b1000;
  localparam exp_t IdMove  = 4'b0111;
  localparam exp_t IdIdle  = 4'b0100;

  initial begin
    rst_n   = 1'b0;
    cmd     = 8'h00;
    cmd_rdy = 1'b0;
    ID      = 8'h00;
    ID_vld  = 1'b0;
    OK2Move = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_transit", {31'b0, in_transit}, 32'd0);
    chk("rst_go", {31'b0, go}, 32'd0);
    chk("rst_buzz", {30'b0, buzz, buzz_n}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_acks", {30'b0, clr_cmd_rdy, clr_ID_vld}, 32'd0);

    // Basic GO and arrive.
    send_cmd(8'h45, CmdMove);
    send_id(8'h05, IdIdle);

    // Wrong station, wrong format, then match.
    send_cmd(8'h4F, CmdMove);
    send_id(8'h37, IdMove);
    send_id(8'hC5, IdMove);
    send_id(8'h0F, IdIdle);

    // Retarget, stale ID, STOP, stray ID while parked.
    send_cmd(8'h41, CmdMove);
    send_cmd(8'h42, CmdMove);
    send_id(8'h01, IdMove);
    send_cmd(8'h00, CmdIdle);
    send_id(8'h02, IdIdle);

    // Reserved opcodes are acknowledged and ignored, in both states.
    send_cmd(8'hC3, CmdIdle);
    send_cmd(8'h45, CmdMove);
    send_cmd(8'h80, CmdMove);
    send_id(8'h05, IdIdle);

    // Simultaneous command and ID: command wins, ID dropped.
    send_cmd(8'h45, CmdMove);
    send(1'b1, 8'h47, 1'b1, 8'h05, 4'b1111);
    send_id(8'h05, IdMove);
    send_id(8'h07, IdIdle);

    // Obstacle tone with half period 4.
    send_cmd(8'h41, CmdMove);
    @(posedge clk);
    #1;
    OK2Move = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic eb;
      @(negedge clk);
      eb = (k / 4) % 2 == 1;
      chk("blocked_go", {31'b0, go}, 32'd0);
      chk("tone_legs", {30'b0, buzz, buzz_n}, (k == 0) ? 32'd0 : {30'b0, eb, ~eb});
    end
    @(posedge clk);
    #1;
    OK2Move = 1'b1;
    @(negedge clk);
    chk("clear_go", {31'b0, go}, 32'd1);
    @(negedge clk);
    chk("tone_off", {30'b0, buzz, buzz_n}, 32'd0);
    chk("still_moving", {31'b0, in_transit}, 32'd1);

    // Reset mid-transit while buzzing.
    @(posedge clk);
    #1;
    OK2Move = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_buzzing", {31'b0, buzz ^ buzz_n}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_transit", {31'b0, in_transit}, 32'd0);
    chk("async_rst_go", {31'b0, go}, 32'd0);
    chk("async_rst_buzz", {30'b0, buzz, buzz_n}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    OK2Move = 1'b1;
    send_id(8'h01, IdIdle);

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
